vrf_wb_arbiter: RTL



---
 rtl/vgpu_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/vrf_wb_arbiter.sv | 80 ++++++++
 3 files changed

// File: rtl/vgpu_pkg.sv
// Shared vector-GPU types and default geometry for the register-file writeback path.
package vgpu_pkg;

  localparam int DEF_LANES      = 4;
  localparam int DEF_VREGS      = 32;
  localparam int DEF_VREG_WIDTH = 32;

  typedef logic [$clog2(DEF_VREGS)-1:0]  vreg_idx_t;
  typedef logic [DEF_VREG_WIDTH-1:0]     lane_t;
  typedef lane_t [DEF_LANES-1:0]         vreg_data_t;

  // Round-robin successor of the last winner.
  function automatic int rr_next(input int winner, input int nreq);
    return (winner + 1) % nreq;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr upward (mod NREQ) for the first request.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   winner,
  output logic            any
);

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[(int'(ptr) + k) % NREQ]) begin
        any                            = 1'b1;
        grant[(int'(ptr) + k) % NREQ]  = 1'b1;
        winner                         = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/vrf_wb_arbiter.sv
// Shares the vector register file write port among NREQ writeback sources and
// tracks a per-vreg busy scoreboard for the issue stage.
module vrf_wb_arbiter
  import vgpu_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int LANES      = DEF_LANES,
  parameter int VREGS      = DEF_VREGS,
  parameter int VREG_WIDTH = DEF_VREG_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NREQ-1:0]                              req_valid,
  input  logic [NREQ-1:0][$clog2(VREGS)-1:0]           req_idx,
  input  logic [NREQ-1:0][LANES-1:0][VREG_WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]                              req_ready,
  output logic                                         vrf_wr_valid,
  output logic [$clog2(VREGS)-1:0]                     vrf_wr_idx,
  output logic [LANES-1:0][VREG_WIDTH-1:0]             vrf_wr_data,
  input  logic                                         vrf_wr_ready,
  input  logic                                         sb_set_valid,
  input  logic [$clog2(VREGS)-1:0]                     sb_set_idx,
  output logic [VREGS-1:0]                             sb_busy
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    winner;
  logic [NREQ-1:0]  grant;
  logic             any_req;
  logic             stage_free;
  logic             accept;
  logic             fire;
  logic [VREGS-1:0] sb_next;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .grant  (grant),
    .winner (winner),
    .any    (any_req)
  );

  assign stage_free = !vrf_wr_valid || vrf_wr_ready;
  assign fire       = vrf_wr_valid && vrf_wr_ready;
  assign accept     = any_req && stage_free;
  // Gating with rst_n keeps every source stalled while reset is held.
  assign req_ready  = (stage_free && rst_n) ? grant : '0;

  // The pointer only moves on accept, so a stalled port never rotates priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vrf_wr_valid <= 1'b0;
      vrf_wr_idx   <= '0;
      vrf_wr_data  <= '0;
      rr_ptr       <= '0;
    end else if (accept) begin
      vrf_wr_valid <= 1'b1;
      vrf_wr_idx   <= req_idx[winner];
      vrf_wr_data  <= req_data[winner];
      rr_ptr       <= PW'(rr_next(int'(winner), NREQ));
    end else if (fire) begin
      vrf_wr_valid <= 1'b0;
    end
  end

  // Set is applied after clear so a freshly issued producer keeps its bit.
  always_comb begin
    sb_next = sb_busy;
    if (fire)         sb_next[vrf_wr_idx] = 1'b0;
    if (sb_set_valid) sb_next[sb_set_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_busy <= '0;
    else        sb_busy <= sb_next;
  end

endmodule
